// File: rtl/button_event_scheduler.sv
// button_event_scheduler
//  Front end for all push-buttons. Each raw input is synchronised, debounced and
//  rising-edge detected, which gives one event per press. Pending presses are then
//  scheduled round-robin onto a single valid/ready event stream.
//  Optional feature: `define HOLD_REPEAT_EN adds auto-repeat while a button is held.
//  Without it, no repeat logic is built and a held button gives exactly one event.
// Ports
//  clk        system clock, posedge
//  rst_n      asynchronous active-low reset
//  btn_raw    raw asynchronous button levels, 1 = pushed
//  evt_valid  event available (registered)
//  evt_ready  consumer accepts the event when evt_valid && evt_ready
//  evt_idx    index of the button that produced the event (registered)
//  pressed    debounced button levels (registered)
//  overrun    1-cycle pulse: a new edge arrived while that button was already pending
module button_event_scheduler #(
   parameter int unsigned N_BTN           = 5,
   parameter int unsigned CNT_W           = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000,
   localparam int unsigned IDX_W          = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [IDX_W-1:0] evt_idx,
   output logic [N_BTN-1:0] pressed,
   output logic             overrun
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_BTN-1:0] sync1_q, sync2_q;
   logic [N_BTN-1:0] stable_q, stable_d;
   logic [CNT_W-1:0] db_cnt_q [N_BTN];
   logic [CNT_W-1:0] db_cnt_d [N_BTN];
   logic [N_BTN-1:0] pending_q, pending_d;
   logic [IDX_W-1:0] last_grant_q, last_grant_d;
   logic             evt_valid_q, evt_valid_d;
   logic [IDX_W-1:0] evt_idx_q, evt_idx_d;
   logic             overrun_q, overrun_d;
   logic [N_BTN-1:0] rise;
   logic [N_BTN-1:0] rep_set;
   logic [N_BTN-1:0] pend_cleared;
   logic [IDX_W:0]   pick;

   // Round-robin search starting just above the last grant; returns {hit, idx}.
   function automatic logic [IDX_W:0] rr_pick(input logic [N_BTN-1:0] req,
                                              input logic [IDX_W-1:0] last);
      logic [IDX_W:0] res;
      int unsigned    cand;
      res = '0;
      for (int unsigned k = 1; k <= N_BTN; k++) begin
         cand = 32'(last) + k;
         if (cand >= N_BTN) cand = cand - N_BTN;
         if (!res[IDX_W] && req[IDX_W'(cand)]) res = {1'b1, IDX_W'(cand)};
      end
      return res;
   endfunction

   // Debounce: a level change is accepted after DEBOUNCE_CYCLES disagreeing cycles.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < int'(N_BTN); i++) begin
         db_cnt_d[i] = db_cnt_q[i];
         if (sync2_q[i] == stable_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DB_LAST) begin
            stable_d[i] = sync2_q[i];
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] != '1) begin
            db_cnt_d[i] = db_cnt_q[i] + 1'b1;
         end
      end
      rise = stable_d & ~stable_q;
   end

`ifdef HOLD_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_FIRST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

   logic [CNT_W-1:0] rep_cnt_q [N_BTN];
   logic [CNT_W-1:0] rep_cnt_d [N_BTN];

   // Hold timer: fires REPEAT_DELAY after the edge, then every REPEAT_PERIOD.
   always_comb begin
      rep_set = '0;
      for (int i = 0; i < int'(N_BTN); i++) begin
         rep_cnt_d[i] = rep_cnt_q[i];
         if (!stable_q[i] || rise[i]) begin
            rep_cnt_d[i] = '0;
         end else if (rep_cnt_q[i] == REP_FIRST) begin
            rep_set[i]   = 1'b1;
            rep_cnt_d[i] = REP_RELOAD;
         end else begin
            rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N_BTN); i++) rep_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < int'(N_BTN); i++) rep_cnt_q[i] <= rep_cnt_d[i];
      end
   end
`else
   assign rep_set = '0;
   if (REPEAT_DELAY == 0 && REPEAT_PERIOD == 0) begin : g_repeat_unused
   end
`endif

   // Scheduler: output register refills on every accept or when empty.
   always_comb begin
      evt_valid_d  = evt_valid_q;
      evt_idx_d    = evt_idx_q;
      last_grant_d = last_grant_q;
      pend_cleared = pending_q;
      pick         = rr_pick(pending_q, last_grant_q);
      if (!evt_valid_q || evt_ready) begin
         if (pick[IDX_W]) begin
            evt_valid_d  = 1'b1;
            evt_idx_d    = pick[IDX_W-1:0];
            last_grant_d = pick[IDX_W-1:0];
            pend_cleared[pick[IDX_W-1:0]] = 1'b0;
         end else begin
            evt_valid_d = 1'b0;
         end
      end
      // A new edge on a bit being granted this cycle is kept, not an overrun.
      overrun_d = |(rise & pend_cleared);
      pending_d = pend_cleared | rise | rep_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         stable_q     <= '0;
         pending_q    <= '0;
         last_grant_q <= IDX_W'(N_BTN - 1);
         evt_valid_q  <= 1'b0;
         evt_idx_q    <= '0;
         overrun_q    <= 1'b0;
         for (int i = 0; i < int'(N_BTN); i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q      <= btn_raw;
         sync2_q      <= sync1_q;
         stable_q     <= stable_d;
         pending_q    <= pending_d;
         last_grant_q <= last_grant_d;
         evt_valid_q  <= evt_valid_d;
         evt_idx_q    <= evt_idx_d;
         overrun_q    <= overrun_d;
         for (int i = 0; i < int'(N_BTN); i++) db_cnt_q[i] <= db_cnt_d[i];
      end
   end

   assign evt_valid = evt_valid_q;
   assign evt_idx   = evt_idx_q;
   assign pressed   = stable_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler: N_BTN=4, DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8. Accepted events are logged on the falling
// edge together with the index of the clock edge that loaded them.
module tb_button_event_scheduler;

   localparam int unsigned N  = 4;
   localparam int unsigned IW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  btn_raw;
   logic          evt_valid;
   logic          evt_ready;
   logic [IW-1:0] evt_idx;
   logic [N-1:0]  pressed;
   logic          overrun;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int vcnt   = 0;
   int ocnt   = 0;
   int ev_idx[$];
   int ev_cyc[$];
   int t0;
   int pcyc;
   bit found;

   button_event_scheduler #(
      .N_BTN(N), .CNT_W(16), .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .evt_valid(evt_valid),
      .evt_ready(evt_ready), .evt_idx(evt_idx), .pressed(pressed), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Handshake and pulse log, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n && evt_valid && evt_ready) begin
         ev_idx.push_back(int'(evt_idx));
         ev_cyc.push_back(cyc);
      end
      if (evt_valid) vcnt++;
      if (overrun)   ocnt++;
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      ev_idx.delete();
      ev_cyc.delete();
      vcnt = 0;
      ocnt = 0;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      btn_raw = '0;
      tick(3);
      rst_n = 1'b1;
      tick(2);
   endtask

   initial begin
      rst_n     = 1'b0;
      btn_raw   = '0;
      evt_ready = 1'b0;
      tick(3);
      check("rst_valid",   int'(evt_valid), 0);
      check("rst_idx",     int'(evt_idx),   0);
      check("rst_pressed", int'(pressed),   0);
      check("rst_overrun", int'(overrun),   0);
      rst_n = 1'b1;
      tick(2);

      // 1: single press, one event, long hold gives nothing more
      evt_ready = 1'b1;
      clear_logs();
      btn_raw[2] = 1'b1;
      t0 = cyc;
      tick(5);
      check("t1_pressed_early", int'(pressed), 0);
      tick(1);
      check("t1_pressed", int'(pressed), 4);
      tick(100);
      check("t1_nevt", ev_idx.size(), 1);
      if (ev_idx.size() >= 1) begin
         check("t1_idx", ev_idx[0], 2);
         check("t1_lat", ev_cyc[0] - t0, 7);
      end
      check("t1_vcycles", vcnt, 1);
      check("t1_overrun", ocnt, 0);
      btn_raw = '0;
      tick(12);

      // 2: glitch shorter than the debounce window
      clear_logs();
      btn_raw[1] = 1'b1;
      tick(3);
      btn_raw[1] = 1'b0;
      tick(20);
      check("t2_pressed", int'(pressed), 0);
      check("t2_nevt",    ev_idx.size(), 0);
      check("t2_overrun", ocnt, 0);

      // 3: simultaneous press under back-pressure, fresh arbitration state
      do_reset();
      clear_logs();
      evt_ready = 1'b0;
      btn_raw   = 4'b1011;
      tick(8);
      check("t3_valid_stall", int'(evt_valid), 1);
      check("t3_idx_stall",   int'(evt_idx),   0);
      tick(4);
      check("t3_idx_held", int'(evt_idx), 0);
      check("t3_nevt_stall", ev_idx.size(), 0);
      evt_ready = 1'b1;
      tick(5);
      check("t3_nevt", ev_idx.size(), 3);
      if (ev_idx.size() == 3) begin
         check("t3_ord0", ev_idx[0], 0);
         check("t3_ord1", ev_idx[1], 1);
         check("t3_ord2", ev_idx[2], 3);
         check("t3_b2b1", ev_cyc[1] - ev_cyc[0], 1);
         check("t3_b2b2", ev_cyc[2] - ev_cyc[1], 1);
      end
      check("t3_valid_end", int'(evt_valid), 0);
      btn_raw = '0;
      tick(12);

      // 4: second edge on an already pending button -> overrun, one event
      clear_logs();
      evt_ready  = 1'b0;
      btn_raw[0] = 1'b1;
      tick(8);
      btn_raw[2] = 1'b1;
      tick(8);
      btn_raw[2] = 1'b0;
      tick(8);
      check("t4_no_ovr_yet", ocnt, 0);
      btn_raw[2] = 1'b1;
      tick(8);
      check("t4_ovr_pulse", ocnt, 1);
      evt_ready = 1'b1;
      tick(6);
      check("t4_nevt", ev_idx.size(), 2);
      if (ev_idx.size() == 2) begin
         check("t4_ev0", ev_idx[0], 0);
         check("t4_ev1", ev_idx[1], 2);
      end
      btn_raw = '0;
      tick(12);

      // 5: reset during a stall discards everything
      clear_logs();
      evt_ready = 1'b0;
      btn_raw   = 4'b0111;
      tick(10);
      check("t5_valid_pre", int'(evt_valid), 1);
      #2;
      rst_n   = 1'b0;
      btn_raw = '0;
      #1;
      check("t5_async_valid", int'(evt_valid), 0);
      check("t5_async_pressed", int'(pressed), 0);
      tick(2);
      rst_n     = 1'b1;
      evt_ready = 1'b1;
      tick(20);
      check("t5_nevt_after", ev_idx.size(), 0);
      btn_raw = 4'b1001;
      tick(12);
      check("t5_nevt", ev_idx.size(), 2);
      if (ev_idx.size() == 2) begin
         check("t5_first", ev_idx[0], 0);
         check("t5_second", ev_idx[1], 3);
      end
      btn_raw = '0;
      tick(12);

      // 6: long hold on button 1
      clear_logs();
      btn_raw[1] = 1'b1;
      found = 1'b0;
      pcyc  = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick(1);
         if (pressed[1]) begin
            found = 1'b1;
            pcyc  = cyc;
         end
      end
      check("t6_pressed_seen", int'(found), 1);
      tick(50);
      btn_raw[1] = 1'b0;
      tick(20);
`ifdef HOLD_REPEAT_EN
      check("t6_nevt", ev_idx.size(), 6);
      if (ev_idx.size() == 6) begin
         for (int k = 0; k < 6; k++) begin
            check($sformatf("t6_idx%0d", k), ev_idx[k], 1);
            check($sformatf("t6_off%0d", k), ev_cyc[k] - pcyc,
                  (k == 0) ? 1 : 1 + 20 + 8 * (k - 1));
         end
      end
`else
      check("t6_nevt", ev_idx.size(), 1);
      if (ev_idx.size() == 1) begin
         check("t6_idx", ev_idx[0], 1);
         check("t6_off", ev_cyc[0] - pcyc, 1);
      end
`endif
      check("t6_overrun", ocnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
